gpio_iobank: RTL and testbench

//  Parametrised Wishbone GPIO bank for CMod S6 SoC peripherals. Per-pin mode
//  is push-pull output, open-drain (I2C-style), or input. Inputs pass a
//  2-flop synchroniser, edges are captured in sticky status bits, and a

---
 rtl/gpio_iobank.sv | 132 +++++++++++++
 tb/tb_gpio_iobank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_iobank.sv
// gpio_iobank: Wishbone GPIO bank with push-pull/open-drain/input pins, edge capture and interrupt.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_iobank #(
   parameter int          NPINS       = 16,
   parameter logic [15:0] RESET_OUT   = 16'hffff,
   parameter logic [15:0] RESET_OD    = 16'h0003,
   parameter int          DEBOUNCE_LG = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wb_cyc,
   input  logic             i_wb_stb,
   input  logic             i_wb_we,
   input  logic [1:0]       i_wb_addr,
   input  logic [31:0]      i_wb_data,
   output logic             o_wb_ack,
   output logic             o_wb_stall,
   output logic [31:0]      o_wb_data,
   input  logic [NPINS-1:0] i_pin,
   output logic [NPINS-1:0] o_pin_out,
   output logic [NPINS-1:0] o_pin_oe,
   output logic             o_int
);
   logic [NPINS-1:0] r_out, r_oe, r_od, r_edge, r_ien;
   logic [NPINS-1:0] r_sync1, r_sync2, r_prev;
   logic [1:0]       r_arm;
   logic             r_ack, r_int;
   logic [31:0]      r_rdata;
   logic             w_stb, w_wr;
   logic [NPINS-1:0] w_in, w_lo, w_hi, w_clr, w_set;
   logic             w_arm_step;
   logic [31:0]      w_rd;

   assign w_stb      = i_wb_cyc & i_wb_stb;
   assign w_wr       = w_stb & i_wb_we;
   assign w_lo       = i_wb_data[NPINS-1:0];
   assign w_hi       = i_wb_data[16 +: NPINS];
   assign w_clr      = (w_wr && i_wb_addr == 2'd3) ? w_lo : '0;
   assign w_set      = (r_arm == 2'd3) ? (w_in ^ r_prev) : '0;
   assign o_wb_ack   = r_ack;
   assign o_wb_stall = 1'b0;
   assign o_wb_data  = r_rdata;
   assign o_int      = r_int;
   assign o_pin_out  = ~r_od & r_out;
   assign o_pin_oe   = (r_od & ~r_out) | (~r_od & r_oe);

`ifdef GPIO_DEBOUNCE_EN
   logic [DEBOUNCE_LG-1:0] r_tick_cnt;
   logic [NPINS-1:0]       r_samp, r_deb;
   logic                   w_tick;
   logic [NPINS-1:0]       w_agree;
   assign w_tick     = &r_tick_cnt;
   assign w_agree    = ~(r_samp ^ r_sync2);
   assign w_in       = r_deb;
   assign w_arm_step = w_tick;
   // free-running tick counter; on each tick accept pins whose last two tick samples agree
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tick_cnt <= '0;
         r_samp     <= '0;
         r_deb      <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + {{(DEBOUNCE_LG-1){1'b0}}, 1'b1};
         if (w_tick) begin
            r_samp <= r_sync2;
            r_deb  <= (r_deb & ~w_agree) | (r_sync2 & w_agree);
         end
      end
   end
`else
   assign w_in       = r_sync2;
   assign w_arm_step = 1'b1;
`endif

   // register read mux, unused upper pin bits read as zero
   always_comb begin
      w_rd = 32'h0;
      case (i_wb_addr)
         2'd0:    w_rd = {16'h0, 16'(r_out)};
         2'd1:    w_rd = {16'(r_od), 16'(r_oe)};
         2'd2:    w_rd = {16'h0, 16'(w_in)};
         default: w_rd = {16'(r_ien), 16'(r_edge)};
      endcase
   end

   // bus response: single-cycle registered ack and read data
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ack   <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         r_ack <= w_stb;
         if (w_stb) r_rdata <= w_rd;
      end
   end

   // control registers; OUT writes are bit-masked by the upper half-word
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out <= RESET_OUT[NPINS-1:0];
         r_oe  <= '0;
         r_od  <= RESET_OD[NPINS-1:0];
         r_ien <= '0;
      end else if (w_wr) begin
         if (i_wb_addr == 2'd0) r_out <= (r_out & ~w_hi) | (w_lo & w_hi);
         if (i_wb_addr == 2'd1) begin
            r_oe <= w_lo;
            r_od <= w_hi;
         end
         if (i_wb_addr == 2'd3) r_ien <= w_hi;
      end
   end

   // input synchroniser, edge capture (set beats W1C clear) and interrupt
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
         r_arm   <= 2'd0;
         r_edge  <= '0;
         r_int   <= 1'b0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         r_prev  <= w_in;
         if (w_arm_step && r_arm != 2'd3) r_arm <= r_arm + 2'd1;
         r_edge  <= (r_edge & ~w_clr) | w_set;
         r_int   <= |(r_edge & r_ien);
      end
   end
endmodule

// File: tb/tb_gpio_iobank.sv
// tb_gpio_iobank: directed and randomized checks of gpio_iobank against a register-level model.
module tb_gpio_iobank;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wdat = 32'h0;
   logic        ack, stall, intr;
   logic [31:0] rdat;
   logic [15:0] pin = 16'h0;
   logic [15:0] pout, poe;
   int          checks = 0, errors = 0;
   logic [15:0] m_out, m_oe, m_od, m_edge, m_ien, m_pin;

   gpio_iobank dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .o_wb_ack(ack), .o_wb_stall(stall),
      .o_wb_data(rdat), .i_pin(pin), .o_pin_out(pout), .o_pin_oe(poe), .o_int(intr)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 16'hffff; m_oe = 16'h0; m_od = 16'h0003; m_edge = 16'h0; m_ien = 16'h0;
   endtask

   function automatic logic [31:0] exp_reg(input logic [1:0] a);
      case (a)
         2'd0:    return {16'h0, m_out};
         2'd1:    return {m_od, m_oe};
         2'd2:    return {16'h0, m_pin};
         default: return {m_ien, m_edge};
      endcase
   endfunction

   // pad behaviour per pin: open-drain pulls low only when OUT is 0
   task automatic check_pads(input string tag);
      logic [15:0] eo, ee;
      for (int i = 0; i < 16; i++) begin
         if (m_od[i]) begin eo[i] = 1'b0; ee[i] = !m_out[i]; end
         else begin eo[i] = m_out[i]; ee[i] = m_oe[i]; end
      end
      chk({tag, "_out"}, {16'h0, pout}, {16'h0, eo});
      chk({tag, "_oe"}, {16'h0, poe}, {16'h0, ee});
   endtask

   task automatic check_int(input string tag);
      repeat (2) @(negedge clk);
      chk(tag, {31'h0, intr}, {31'h0, |(m_edge & m_ien)});
   endtask

   task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("ack", {31'h0, ack}, 32'h1);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus(1'b1, a, d);
      case (a)
         2'd0: for (int i = 0; i < 16; i++) if (d[16+i]) m_out[i] = d[i];
         2'd1: begin m_oe = d[15:0]; m_od = d[31:16]; end
         2'd3: begin m_ien = d[31:16]; m_edge = m_edge & ~d[15:0]; end
         default: ;
      endcase
   endtask

   task automatic rd_chk(input logic [1:0] a, input string tag);
      bus(1'b0, a, 32'h0);
      chk(tag, rdat, exp_reg(a));
   endtask

   task automatic set_pins(input logic [15:0] p);
      @(negedge clk);
      pin = p;
      m_edge = m_edge | (m_pin ^ p);
      m_pin = p;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      model_reset();
      m_pin = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_data", rdat, 32'h0);
      chk("rst_int", {31'h0, intr}, 32'h0);
      rst_n = 1'b1;
      rd_chk(2'd0, "t1_out");
      chk("t1_out_lit", rdat, 32'h0000ffff);
      rd_chk(2'd1, "t1_mode");
      chk("t1_mode_lit", rdat, 32'h00030000);
      rd_chk(2'd3, "t1_edge");
      rd_chk(2'd2, "t1_in");
      chk("t1_oe_lit", {16'h0, poe}, 32'h0);
      check_pads("t1");

      wr(2'd0, 32'h00010000);
      chk("t2_oe0", {31'h0, poe[0]}, 32'h1);
      chk("t2_out0", {31'h0, pout[0]}, 32'h0);
      check_pads("t2");

      wr(2'd1, 32'h000000f0);
      wr(2'd0, 32'h00f000a0);
      chk("t3_out74", {28'h0, pout[7:4]}, 32'ha);
      chk("t3_oe74", {28'h0, poe[7:4]}, 32'hf);
      check_pads("t3");

      // edge on pin 2: captured at the 3rd clk, interrupt one clk later
      wr(2'd3, 32'h00040000);
      @(negedge clk);
      pin[2] = 1'b1;
      repeat (3) @(negedge clk);
      chk("t4_int_early", {31'h0, intr}, 32'h0);
      @(negedge clk);
      chk("t4_int", {31'h0, intr}, 32'h1);
      m_edge = 16'h0004; m_pin = 16'h0004;
      rd_chk(2'd3, "t4_edge");
      wr(2'd3, 32'h00000004);
      check_int("t4_int_clr");

      // W1C clear lands in the same clk as a fresh edge on pin 2
      wr(2'd3, 32'h00040000);
      @(negedge clk);
      pin[2] = 1'b0;
      repeat (2) @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd3; wdat = 32'h00040004;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("t5_ack", {31'h0, ack}, 32'h1);
      m_pin = 16'h0; m_edge = 16'h0004;
      rd_chk(2'd3, "t5_edge_kept");
      check_int("t5_int");
      wr(2'd3, 32'h00040004);
      rd_chk(2'd3, "t5_edge_clr");
      check_int("t5_int_clr");

      // four back-to-back reads
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_ack", {31'h0, ack}, 32'h1);
         chk("t6_stall", {31'h0, stall}, 32'h0);
         chk("t6_data", rdat, exp_reg(2'd0));
         if (k == 3) begin cyc = 1'b0; stb = 1'b0; end
      end
      @(negedge clk);
      chk("t6_ack_end", {31'h0, ack}, 32'h0);

      // async reset during the 2nd strobe drops the ack immediately
      cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("t6_ack1", {31'h0, ack}, 32'h1);
      #2 rst_n = 1'b0;
      #1 chk("t6_rst_ack", {31'h0, ack}, 32'h0);
      chk("t6_rst_data", rdat, 32'h0);
      cyc = 1'b0; stb = 1'b0;
      pin = 16'h0030;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      m_pin = 16'h0030;
      repeat (6) @(negedge clk);
      rd_chk(2'd3, "arm_suppress");
      rd_chk(2'd2, "arm_in");
      check_pads("post_rst");

      // randomized register and pin traffic
      for (int n = 0; n < 60; n++) begin
         logic [31:0] d;
         logic [1:0]  a;
         d = $urandom;
         a = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: wr(2'd0, d);
            1: wr(2'd1, d);
            2: wr(2'd3, d);
            3: set_pins(d[15:0]);
            default: ;
         endcase
         check_pads("rnd_pads");
         check_int("rnd_int");
         rd_chk(a, "rnd_rd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
